// File: rtl/sb_pkg.sv
// Shared sideband constants used by the TX FIFO slice.
package sb_pkg;

    localparam int unsigned SB_PKT_W         = 64;
    localparam int unsigned SB_TX_FIFO_DEPTH = 4;

endpackage

// File: rtl/sb_tx_param_fifo_if.sv
// Push/pop/status bundle between the sideband encoder, the TX FIFO and the serializer.
interface sb_tx_param_fifo_if
    import sb_pkg::*;
#(
    parameter int unsigned DATA_W = SB_PKT_W,
    parameter int unsigned DEPTH  = SB_TX_FIFO_DEPTH
);

    logic                     i_write_enable;
    logic [DATA_W-1:0]        i_data_in;
    logic                     i_read_enable;
    logic                     i_flush;
    logic [DATA_W-1:0]        o_data_out;
    logic                     o_empty;
    logic                     o_full;
    logic                     o_almost_full;
    logic [$clog2(DEPTH):0]   o_count;
    logic                     o_ser_done_sampled;
    logic                     o_overflow;
    logic                     o_underflow;

    modport master (
        output i_write_enable, i_data_in, i_read_enable, i_flush,
        input  o_data_out, o_empty, o_full, o_almost_full, o_count,
               o_ser_done_sampled, o_overflow, o_underflow
    );

    modport slave (
        input  i_write_enable, i_data_in, i_read_enable, i_flush,
        output o_data_out, o_empty, o_full, o_almost_full, o_count,
               o_ser_done_sampled, o_overflow, o_underflow
    );

endinterface

// File: rtl/sb_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write, combinational read, no reset.
module sb_fifo_mem
    import sb_pkg::*;
#(
    parameter int unsigned DATA_W = SB_PKT_W,
    parameter int unsigned DEPTH  = SB_TX_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sb_tx_param_fifo.sv
// Sideband TX FIFO: pointers, push/pop acceptance, sticky error flags and read-data register.
module sb_tx_param_fifo
    import sb_pkg::*;
#(
    parameter int unsigned DATA_W       = SB_PKT_W,
    parameter int unsigned DEPTH        = SB_TX_FIFO_DEPTH,
    parameter int unsigned AFULL_THRESH = DEPTH - 1,
    parameter bit          FWFT         = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    sb_tx_param_fifo_if.slave bus
);

    localparam int unsigned      AW      = $clog2(DEPTH);
    localparam int unsigned      PW      = AW + 1;
    localparam logic [PW-1:0]    DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0]    AFULL_P = PW'(AFULL_THRESH);

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     count;
    logic              rd_ok;
    logic              wr_ok;
    logic              mem_we;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] dout_q;
    logic              overflow;
    logic              underflow;
    logic              ser_done;

    // A pop in the same cycle frees a slot, so a push while full is still accepted.
    always_comb begin
        count  = wr_ptr - rd_ptr;
        rd_ok  = bus.i_read_enable && (count != '0);
        wr_ok  = bus.i_write_enable && ((count < DEPTH_P) || rd_ok);
        mem_we = wr_ok && !bus.i_flush;
    end

    sb_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (i_clk),
        .we    (mem_we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (bus.i_data_in),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            dout_q    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            ser_done  <= 1'b0;
        end else begin
            ser_done <= bus.i_read_enable;
            if (bus.i_flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                dout_q    <= '0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (wr_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (rd_ok) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    dout_q <= rdata;
                end
                if (bus.i_write_enable && !wr_ok) begin
                    overflow <= 1'b1;
                end
                if (bus.i_read_enable && !rd_ok) begin
                    underflow <= 1'b1;
                end
            end
        end
    end

    assign bus.o_count            = count;
    assign bus.o_empty            = (count == '0);
    assign bus.o_full             = (count == DEPTH_P);
    assign bus.o_almost_full      = (count >= AFULL_P);
    assign bus.o_overflow         = overflow;
    assign bus.o_underflow        = underflow;
    assign bus.o_ser_done_sampled = ser_done;
    assign bus.o_data_out         = FWFT ? ((count != '0) ? rdata : '0) : dout_q;

endmodule
